// File: rtl/counter_sched.sv
// Round-robin scheduler that lends one shared up/down step counter to NREQ requesters,
// issuing exactly the requested number of enable cycles per granted job.
module counter_sched #(
    parameter int NREQ = 2,
    parameter int SW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      dir,
    input  logic [NREQ*SW-1:0]   steps,
    output logic [NREQ-1:0]      gnt,
    output logic                 cnt_en,
    output logic                 cnt_dir,
    output logic                 done,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rrPtr;
    logic [PW-1:0]   r_winner;
    logic [SW-1:0]   r_rem;
    logic [NREQ-1:0] r_gnt;
    logic            r_cntEn;
    logic            r_cntDir;
    logic            r_done;
    logic            r_busy;

    logic [SW-1:0]   w_stepsArr [NREQ];
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_winner;
    logic            w_found;
    logic [SW-1:0]   w_stepsSel;
    logic [NREQ-1:0] w_oneHot;
    logic [PW-1:0]   w_nextPtr;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_stepsArr[g] = steps[g*SW +: SW];
    end

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(r_rrPtr) + k) % NREQ);
            if (req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_stepsSel = w_stepsArr[w_winner];
    assign w_oneHot   = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_nextPtr  = (int'(r_winner) == NREQ - 1) ? '0 : r_winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rrPtr  <= '0;
            r_winner <= '0;
            r_rem    <= '0;
            r_gnt    <= '0;
            r_cntEn  <= 1'b0;
            r_cntDir <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_winner <= w_winner;
                        r_gnt    <= w_oneHot;
                        r_busy   <= 1'b1;
                        if (w_stepsSel == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RUN;
                            r_rem    <= w_stepsSel;
                            r_cntEn  <= 1'b1;
                            r_cntDir <= dir[w_winner];
                        end
                    end
                end
                RUN: begin
                    r_rem <= r_rem - 1'b1;
                    // A dropped request aborts silently but still rotates priority.
                    if (!req[r_winner]) begin
                        r_state  <= IDLE;
                        r_gnt    <= '0;
                        r_cntEn  <= 1'b0;
                        r_cntDir <= 1'b0;
                        r_busy   <= 1'b0;
                        r_rrPtr  <= w_nextPtr;
                    end else if (r_rem == SW'(1)) begin
                        r_state  <= DONE;
                        r_cntEn  <= 1'b0;
                        r_cntDir <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_rrPtr <= w_nextPtr;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign cnt_en  = r_cntEn;
    assign cnt_dir = r_cntDir;
    assign done    = r_done;
    assign busy    = r_busy;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: a scoreboard queue of expected jobs is checked by a
// negedge monitor that measures each grant's enable run, direction and done pulse.
module tb_counter_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] dir;
    logic [7:0] steps;
    logic [1:0] gnt;
    logic       cnt_en;
    logic       cnt_dir;
    logic       done;
    logic       busy;

    logic [2:0] cnt3;
    logic       cntClr;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] gnt;
        logic       dir;
        int         cnt;
        logic       done;
    } job_t;

    job_t scoreQ[$];

    counter_sched #(.NREQ(2), .SW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .dir     (dir),
        .steps   (steps),
        .gnt     (gnt),
        .cnt_en  (cnt_en),
        .cnt_dir (cnt_dir),
        .done    (done),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External 3-bit up/down counter driven by the scheduler.
    always @(posedge clk) begin
        if (cntClr) cnt3 <= 3'd0;
        else if (cnt_en) cnt3 <= cnt_dir ? cnt3 + 3'd1 : cnt3 - 3'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d, input logic [7:0] s);
        req   = r;
        dir   = d;
        steps = s;
    endtask

    task automatic pushJob(input logic [1:0] g, input logic d, input int n, input logic dn);
        job_t j;
        j.gnt  = g;
        j.dir  = d;
        j.cnt  = n;
        j.done = dn;
        scoreQ.push_back(j);
    endtask

    task automatic waitDrain(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (scoreQ.size() == 0) break;
        end
        checkOutput("drain", 32'(scoreQ.size()), 0);
    endtask

    task automatic clearCounter();
        cntClr = 1'b1;
        @(posedge clk);
        #1;
        cntClr = 1'b0;
    endtask

    // Monitor: one scoreboard entry is consumed per grant, at done or at grant withdrawal.
    logic       inJob = 1'b0;
    logic [1:0] curGnt;
    int         enCount;
    logic       dirErr;
    job_t       curExp;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (inJob && scoreQ.size() > 0) void'(scoreQ.pop_front());
            inJob = 1'b0;
        end else begin
            if (!inJob && gnt != 2'b00) begin
                inJob   = 1'b1;
                curGnt  = gnt;
                enCount = 0;
                dirErr  = 1'b0;
                checkOutput("grant_expected", 32'(scoreQ.size() != 0), 1);
                if (scoreQ.size() > 0) curExp = scoreQ[0];
                else curExp = '{gnt: 2'b00, dir: 1'b0, cnt: -1, done: 1'b0};
            end
            if (inJob) begin
                if (cnt_en) begin
                    enCount++;
                    if (cnt_dir !== curExp.dir) dirErr = 1'b1;
                end else if (cnt_dir !== 1'b0) begin
                    dirErr = 1'b1;
                end
                if (done || gnt == 2'b00) begin
                    checkOutput("job_gnt", 32'(done ? gnt : curGnt), 32'(curExp.gnt));
                    checkOutput("job_en_cycles", 32'(enCount), 32'(curExp.cnt));
                    checkOutput("job_done", 32'(done), 32'(curExp.done));
                    checkOutput("job_dir", 32'(dirErr), 0);
                    if (scoreQ.size() > 0) void'(scoreQ.pop_front());
                    inJob = 1'b0;
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        cntClr = 1'b0;
        applyStimulus(2'b00, 2'b00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_gnt", 32'(gnt), 0);
        checkOutput("reset_cnt_en", 32'(cnt_en), 0);
        checkOutput("reset_cnt_dir", 32'(cnt_dir), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        clearCounter();

        // Single job, up by 3.
        $display("[TB] single job");
        pushJob(2'b01, 1'b1, 3, 1'b1);
        applyStimulus(2'b01, 2'b01, {4'd0, 4'd3});
        waitDrain(50);
        applyStimulus(2'b00, 2'b00, 8'h00);
        checkOutput("single_busy_after", 32'(busy), 0);
        checkOutput("single_counter", 32'(cnt3), 3);

        // Contention: pointer now favours requester 1.
        $display("[TB] contention");
        pushJob(2'b10, 1'b1, 2, 1'b1);
        pushJob(2'b01, 1'b0, 2, 1'b1);
        pushJob(2'b10, 1'b1, 2, 1'b1);
        pushJob(2'b01, 1'b0, 2, 1'b1);
        applyStimulus(2'b11, 2'b10, {4'd2, 4'd2});
        waitDrain(100);
        applyStimulus(2'b00, 2'b00, 8'h00);
        checkOutput("contention_busy_after", 32'(busy), 0);

        // Zero-length job on requester 1.
        $display("[TB] zero length");
        pushJob(2'b10, 1'b1, 0, 1'b1);
        applyStimulus(2'b10, 2'b10, {4'd0, 4'd5});
        waitDrain(50);
        applyStimulus(2'b00, 2'b00, 8'h00);

        // Abort after 4 enabled cycles, then requester 1 must win.
        $display("[TB] abort");
        pushJob(2'b01, 1'b1, 4, 1'b0);
        applyStimulus(2'b01, 2'b01, {4'd0, 4'd10});
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(2'b00, 2'b01, {4'd0, 4'd10});
        waitDrain(50);
        checkOutput("abort_busy_after", 32'(busy), 0);
        pushJob(2'b10, 1'b1, 1, 1'b1);
        pushJob(2'b01, 1'b1, 1, 1'b1);
        applyStimulus(2'b11, 2'b11, {4'd1, 4'd1});
        waitDrain(50);
        applyStimulus(2'b00, 2'b00, 8'h00);

        // Maximum length, counting down from zero.
        $display("[TB] max down");
        clearCounter();
        pushJob(2'b10, 1'b0, 15, 1'b1);
        applyStimulus(2'b10, 2'b00, {4'd15, 4'd0});
        waitDrain(100);
        applyStimulus(2'b00, 2'b00, 8'h00);
        checkOutput("maxdown_counter", 32'(cnt3), 1);

        // Reset mid-run: outputs clear without a clock edge.
        $display("[TB] reset mid-run");
        pushJob(2'b01, 1'b1, 0, 1'b0);
        applyStimulus(2'b01, 2'b01, {4'd0, 4'd10});
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrun_cnt_en_before", 32'(cnt_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_gnt", 32'(gnt), 0);
        checkOutput("midrun_cnt_en", 32'(cnt_en), 0);
        checkOutput("midrun_done", 32'(done), 0);
        checkOutput("midrun_busy", 32'(busy), 0);
        applyStimulus(2'b00, 2'b00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_reset_done", 32'(done), 0);
        checkOutput("post_reset_busy", 32'(busy), 0);
        checkOutput("post_reset_queue", 32'(scoreQ.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
